// File: rtl/patch_pkg.sv
// Shared definitions for the patch command parser: command bytes, FSM state
// encoding, default patch length and the checksum accumulate helper.
package patch_pkg;

    localparam logic [7:0] CMD_LOAD    = 8'h3A;  // ':' start a patch load
    localparam logic [7:0] CMD_RST_IDX = 8'h26;  // '&' rewind readback index
    localparam logic [7:0] CMD_READ    = 8'h2A;  // '*' read back one live byte
    localparam logic [7:0] CMD_RESET   = 8'h21;  // '!' restart the target reset hammer

    localparam int PATCH_LEN_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CHECK   = 2'd2,
        ST_TX_WAIT = 2'd3
    } state_e;

    // Running 8-bit checksum: sum of data bytes modulo 256.
    function automatic logic [7:0] sum8_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/patch_timeout.sv
// Inter-byte timeout: loadable down-counter. load_i reloads the full window;
// while en_i is high the window drains one per cycle and expired_o strobes
// on the last cycle of an uninterrupted window.
module patch_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and expiry strobe; a reload always wins over expiry.
    always_comb begin
        cnt_d     = cnt_q;
        expired_o = 1'b0;
        if (load_i) begin
            cnt_d = CW'(TIMEOUT_CYCLES);
        end else if (en_i) begin
            if (cnt_q == CW'(1)) begin
                expired_o = 1'b1;
                cnt_d     = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/patch_cmd_parser.sv
// UART command parser that loads a patch into a shadow buffer, commits it
// atomically into the live table read by the SPI flash responder, reads live
// bytes back over UART and requests target resets.
// Optional build macro PATCH_CHECKSUM_EN: a load carries one extra trailing
// byte (8-bit sum of the data bytes) and commits only when it matches.
// PATCH_LEN must not exceed 16 (the live table spans the 4-bit address space).
module patch_cmd_parser
    import patch_pkg::*;
#(
    parameter int          PATCH_LEN      = PATCH_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_s,
    input  logic       rstn_s,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_send,
    output logic [7:0] tx_data,
    input  logic [3:0] patch_addr,
    output logic [7:0] patch_data,
    output logic       patch_valid,
    output logic       target_rst_req,
    output logic       err
);

`ifdef PATCH_CHECKSUM_EN
    localparam int LOAD_BYTES = PATCH_LEN + 1;
`else
    localparam int LOAD_BYTES = PATCH_LEN;
`endif
    localparam int CNT_W = $clog2(LOAD_BYTES + 1);
    localparam int IDX_W = $clog2(PATCH_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       rd_idx_q;
    logic [7:0]       shadow_q [PATCH_LEN];
    logic [7:0]       live_q   [16];
    logic             tx_send_q, err_q, rst_req_q, patch_valid_q;
    logic [7:0]       tx_data_q;
`ifdef PATCH_CHECKSUM_EN
    logic [7:0]       sum_q, chk_q;
`endif

    logic tx_send_d, err_d, rst_req_d;
    logic shadow_we_s, commit_s, abort_s, cnt_clr_s;
    logic rd_clr_s, rd_inc_s, tx_latch_s;
    logic tmo_expired_s, in_load_s, data_byte_s;

    assign in_load_s   = (state_q == ST_LOAD);
    assign data_byte_s = (cnt_q < CNT_W'(PATCH_LEN));

    patch_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_s),
        .rst_ni   (rstn_s),
        .load_i   (rx_valid),
        .en_i     (in_load_s),
        .expired_o(tmo_expired_s)
    );

    // FSM next state and per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        tx_send_d   = 1'b0;
        err_d       = 1'b0;
        rst_req_d   = 1'b0;
        shadow_we_s = 1'b0;
        commit_s    = 1'b0;
        abort_s     = 1'b0;
        cnt_clr_s   = 1'b0;
        rd_clr_s    = 1'b0;
        rd_inc_s    = 1'b0;
        tx_latch_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD: begin
                            cnt_clr_s = 1'b1;
                            state_d   = ST_LOAD;
                        end
                        CMD_RST_IDX: rd_clr_s = 1'b1;
                        CMD_READ: begin
                            tx_latch_s = 1'b1;
                            rd_inc_s   = 1'b1;
                            state_d    = ST_TX_WAIT;
                        end
                        CMD_RESET: rst_req_d = 1'b1;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (rx_valid) begin
                    shadow_we_s = 1'b1;
                    if (cnt_q == CNT_W'(LOAD_BYTES - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (tmo_expired_s) begin
                    abort_s = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CHECK: begin
                err_d   = rx_valid;
                state_d = ST_IDLE;
`ifdef PATCH_CHECKSUM_EN
                if (sum_q == chk_q) begin
                    commit_s = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
`else
                commit_s = 1'b1;
`endif
            end
            ST_TX_WAIT: begin
                err_d = rx_valid;
                if (tx_ready) begin
                    tx_send_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered output strobes / transmit byte / valid flag.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            state_q       <= ST_IDLE;
            tx_send_q     <= 1'b0;
            err_q         <= 1'b0;
            rst_req_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            patch_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_send_q <= tx_send_d;
            err_q     <= err_d;
            rst_req_q <= rst_req_d;
            if (tx_latch_s) begin
                tx_data_q <= live_q[rd_idx_q];
            end
            if (commit_s) begin
                patch_valid_q <= 1'b1;
            end
        end
    end

    // Load byte counter and readback index (index wraps 15 -> 0 naturally).
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            cnt_q    <= '0;
            rd_idx_q <= 4'd0;
        end else begin
            if (cnt_clr_s) begin
                cnt_q <= '0;
            end else if (shadow_we_s) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (rd_clr_s) begin
                rd_idx_q <= 4'd0;
            end else if (rd_inc_s) begin
                rd_idx_q <= rd_idx_q + 4'd1;
            end
        end
    end

    // Shadow buffer: filled during a load, wiped when a load times out.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            for (int i = 0; i < PATCH_LEN; i++) shadow_q[i] <= 8'h00;
        end else if (abort_s) begin
            for (int i = 0; i < PATCH_LEN; i++) shadow_q[i] <= 8'h00;
        end else if (shadow_we_s && data_byte_s) begin
            shadow_q[cnt_q[IDX_W-1:0]] <= rx_data;
        end
    end

`ifdef PATCH_CHECKSUM_EN
    // Running sum of data bytes and the received checksum byte.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            sum_q <= 8'h00;
            chk_q <= 8'h00;
        end else if (cnt_clr_s) begin
            sum_q <= 8'h00;
        end else if (shadow_we_s && data_byte_s) begin
            sum_q <= sum8_add(sum_q, rx_data);
        end else if (shadow_we_s) begin
            chk_q <= rx_data;
        end
    end
`endif

    // Live table: whole shadow copied in one edge so readers never see a mix.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            for (int i = 0; i < 16; i++) live_q[i] <= 8'h00;
        end else if (commit_s) begin
            for (int i = 0; i < PATCH_LEN; i++) live_q[i] <= shadow_q[i];
        end
    end

    assign patch_data     = live_q[patch_addr];
    assign tx_send        = tx_send_q;
    assign tx_data        = tx_data_q;
    assign patch_valid    = patch_valid_q;
    assign target_rst_req = rst_req_q;
    assign err            = err_q;

endmodule
